// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: reset PC, next-PC select codes, nop.
package mips_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;

    localparam logic [1:0]  NPC_SEQ   = 2'b00;
    localparam logic [1:0]  NPC_BR    = 2'b01;
    localparam logic [1:0]  NPC_J     = 2'b10;
    localparam logic [1:0]  NPC_JR    = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/npc.sv
// Combinational next-PC calculator for the fetch stage (delay-slot semantics:
// redirect targets are relative to the D-stage instruction, not the current PC).
module npc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] d_pc_i,
    input  logic [31:0] d_instr_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        br_cond_i,
    input  logic [31:0] rs_val_i,
    input  logic        d_valid_i,
    output logic [31:0] npc_o
);

    logic [31:0] pc_plus4;
    logic [31:0] d_pc_plus4;
    logic [31:0] br_offset;
    logic        unused_instr_bits;

    assign pc_plus4          = pc_i + 32'd4;
    assign d_pc_plus4        = d_pc_i + 32'd4;
    assign br_offset         = {{14{d_instr_i[15]}}, d_instr_i[15:0], 2'b00};
    // Opcode field is decoded in D; only the immediate/target fields matter here.
    assign unused_instr_bits = ^d_instr_i[31:26];

    // Select the next PC; a bubble in IF/ID can never redirect.
    always_comb begin
        npc_o = pc_plus4;
        if (d_valid_i) begin
            case (npc_sel_i)
                NPC_BR:  npc_o = br_cond_i ? (d_pc_plus4 + br_offset) : pc_plus4;
                NPC_J:   npc_o = {d_pc_plus4[31:28], d_instr_i[25:0], 2'b00};
                NPC_JR:  npc_o = rs_val_i;
                default: npc_o = pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, range flag.
module fetch_unit
    import mips_pkg::NOP_INSTR;
#(
    parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_cond,
    input  logic [31:0] rs_val,
    input  logic [31:0] im_instr,
    output logic [31:0] im_addr,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_valid,
    output logic        pc_oob
);

    localparam logic [31:0] IM_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd1;

    logic [31:0] pc_q, pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic        d_valid_q, d_valid_d;
    logic [31:0] npc;

    npc u_npc (
        .pc_i      (pc_q),
        .d_pc_i    (d_pc_q),
        .d_instr_i (d_instr_q),
        .npc_sel_i (npc_sel),
        .br_cond_i (br_cond),
        .rs_val_i  (rs_val),
        .d_valid_i (d_valid_q),
        .npc_o     (npc)
    );

    // Next state: stall freezes PC and IF/ID, discarding any redirect this cycle.
    always_comb begin
        pc_d      = pc_q;
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        d_valid_d = d_valid_q;
        if (!stall) begin
            pc_d      = npc;
            d_instr_d = im_instr;
            d_pc_d    = pc_q;
            d_valid_d = 1'b1;
        end
    end

    // PC and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= PC_RESET;
            d_instr_q <= NOP_INSTR;
            d_pc_q    <= 32'd0;
            d_valid_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign im_addr = pc_q;
    assign d_instr = d_instr_q;
    assign d_pc    = d_pc_q;
    assign d_pc8   = d_pc_q + 32'd8;
    assign d_valid = d_valid_q;
    // Memory aliases out-of-range addresses; this flag lets later stages notice.
    assign pc_oob  = (pc_q < PC_RESET) || (pc_q > IM_LAST) || (pc_q[1:0] != 2'b00);

endmodule
